// File: rtl/attention_av_feeder.sv
// attention_av_feeder
// Producer side of the attention AV-multiply interface. A serial element
// stream carrying one head-batch (A weights, then V values, plus per-token
// precision codes) is assembled into the flattened A/V buses and the
// precision array. A one-cycle start is then issued and the buses are held
// stable until the multiplier reports done.
//
// Optional feature macro: AUTO_PRECISION_EN
//   undefined : token precision is captured from s_prec on the first V beat
//               of each token.
//   defined   : s_prec is ignored; the code is derived from V magnitudes
//               (2 if any bits above bit 7 are set, else 1 if bits [7:4]
//               are set, else 0) and written on the token's last V beat.

module attention_av_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic [3:0]                   s_prec,
  output logic [DATA_WIDTH*L*N*L-1:0]  A_out,
  output logic [DATA_WIDTH*L*N*E-1:0]  V_out,
  output logic [3:0]                   token_precision_out [L-1:0],
  output logic                         mult_start,
  input  logic                         mult_done,
  output logic                         busy,
  output logic                         batch_done
);

  // Element counts per phase and counter widths
  localparam int NUM_A   = L * N * L;
  localparam int NUM_V   = L * N * E;
  localparam int TOK_LEN = N * E;
  localparam int CNT_MAX = (NUM_A > NUM_V) ? NUM_A : NUM_V;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int TW      = $clog2(L) + 1;
  localparam int BW      = $clog2(TOK_LEN) + 1;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_V = 2'd1,
    S_START  = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;        // flat element index within the current phase
  logic [TW-1:0]   r_tok;        // token index l2 during the V phase
  logic [BW-1:0]   r_beat;       // beat position inside the current token
  logic            r_s_ready;
  logic            r_mult_start;
  logic            r_busy;
  logic            r_batch_done;

  logic            w_accept;
  logic            w_a_wr;
  logic            w_v_wr;
  logic            w_a_last;
  logic            w_v_last;
  logic            w_tok_first;
  logic            w_tok_end;
  logic            w_prec_wr;
  logic [3:0]      w_prec_val;

  assign w_accept    = s_valid & r_s_ready;
  assign w_a_wr      = w_accept && (r_state == S_LOAD_A);
  assign w_v_wr      = w_accept && (r_state == S_LOAD_V);
  assign w_a_last    = (r_cnt == CW'(NUM_A - 1));
  assign w_v_last    = (r_cnt == CW'(NUM_V - 1));
  assign w_tok_first = (r_beat == '0);
  assign w_tok_end   = (r_beat == BW'(TOK_LEN - 1));

  assign s_ready    = r_s_ready;
  assign mult_start = r_mult_start;
  assign busy       = r_busy;
  assign batch_done = r_batch_done;

  // Batch sequencing: load A, load V, pulse start, wait for done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_LOAD_A;
      r_cnt        <= '0;
      r_tok        <= '0;
      r_beat       <= '0;
      r_s_ready    <= 1'b0;
      r_mult_start <= 1'b0;
      r_busy       <= 1'b0;
      r_batch_done <= 1'b0;
    end else begin
      r_mult_start <= 1'b0;
      r_batch_done <= 1'b0;
      case (r_state)
        S_LOAD_A: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            if (w_a_last) begin
              r_cnt   <= '0;
              r_tok   <= '0;
              r_beat  <= '0;
              r_state <= S_LOAD_V;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LOAD_V: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            if (w_v_last) begin
              // Final beat: ready drops and start fires on the next cycle
              r_cnt        <= '0;
              r_tok        <= '0;
              r_beat       <= '0;
              r_s_ready    <= 1'b0;
              r_mult_start <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= S_START;
            end else begin
              r_cnt <= r_cnt + CW'(1);
              if (w_tok_end) begin
                r_beat <= '0;
                r_tok  <= r_tok + TW'(1);
              end else begin
                r_beat <= r_beat + BW'(1);
              end
            end
          end
        end
        S_START, S_WAIT: begin
          // A done arriving in the start cycle is honoured like one in wait
          r_s_ready <= 1'b0;
          if (mult_done) begin
            r_busy       <= 1'b0;
            r_batch_done <= 1'b1;
            r_s_ready    <= 1'b1;
            r_state      <= S_LOAD_A;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state   <= S_LOAD_A;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef AUTO_PRECISION_EN
  logic [1:0] r_code;
  logic [1:0] w_beat_cls;
  logic [1:0] w_code_run;
  logic       w_unused_prec;

  // s_prec has no role when the code is derived from the data
  assign w_unused_prec = ^s_prec;

  // Magnitude class of the current beat
  assign w_beat_cls = (|s_data[DATA_WIDTH-1:8]) ? 2'd2 :
                      (|s_data[7:4])            ? 2'd1 : 2'd0;

  // Running maximum restarts on each token's first V beat
  assign w_code_run = w_tok_first ? w_beat_cls :
                      ((w_beat_cls > r_code) ? w_beat_cls : r_code);

  assign w_prec_wr  = w_v_wr && w_tok_end;
  assign w_prec_val = {2'b00, w_code_run};

  // Track the running code across the beats of a token
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= 2'd0;
    end else if (w_v_wr) begin
      r_code <= w_code_run;
    end
  end
`else
  logic w_unused_tok_end;

  // Only the first beat of a token matters when capturing s_prec
  assign w_unused_tok_end = w_tok_end;
  assign w_prec_wr        = w_v_wr && w_tok_first;
  assign w_prec_val       = s_prec;
`endif

  // A bus: one register per element, written when the counter points at it
  for (genvar gi = 0; gi < NUM_A; gi++) begin : g_a
    logic [DATA_WIDTH-1:0] r_elem;

    // Element store, held across start/wait because no beats are accepted
    always_ff @(posedge clk) begin
      if (rst) begin
        r_elem <= '0;
      end else if (w_a_wr && (r_cnt == CW'(gi))) begin
        r_elem <= s_data;
      end
    end

    assign A_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_elem;
  end

  // V bus: same scheme, indexed l2*N*E + n*E + e
  for (genvar gi = 0; gi < NUM_V; gi++) begin : g_v
    logic [DATA_WIDTH-1:0] r_elem;

    // Element store, previous batch remains visible until overwritten
    always_ff @(posedge clk) begin
      if (rst) begin
        r_elem <= '0;
      end else if (w_v_wr && (r_cnt == CW'(gi))) begin
        r_elem <= s_data;
      end
    end

    assign V_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_elem;
  end

  // Per-token precision codes
  for (genvar gi = 0; gi < L; gi++) begin : g_prec
    logic [3:0] r_code_tok;

    // Code update for token gi on its capture beat
    always_ff @(posedge clk) begin
      if (rst) begin
        r_code_tok <= 4'd0;
      end else if (w_prec_wr && (r_tok == TW'(gi))) begin
        r_code_tok <= w_prec_val;
      end
    end

    assign token_precision_out[gi] = r_code_tok;
  end

endmodule

// File: tb/tb_attention_av_feeder.sv
// Bench for attention_av_feeder (default parameters: 16-bit data, L=8, N=1, E=8).
// A behavioural model tracks the batch as a list of beats and arrays of
// expected bus contents; every cycle the DUT outputs are compared with it.
// Directed tests pin absolute values computed by hand.

module tb_attention_av_feeder;

  localparam int DW    = 16;
  localparam int L     = 8;
  localparam int N     = 1;
  localparam int E     = 8;
  localparam int NA    = L * N * L;
  localparam int NV    = L * N * E;
  localparam int TOK   = N * E;
  localparam int NBEAT = NA + NV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic [3:0]        s_prec;
  logic [DW*NA-1:0]  A_out;
  logic [DW*NV-1:0]  V_out;
  logic [3:0]        tpo [L-1:0];
  logic              mult_start;
  logic              mult_done;
  logic              busy;
  logic              batch_done;

  attention_av_feeder #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_data              (s_data),
    .s_prec              (s_prec),
    .A_out               (A_out),
    .V_out               (V_out),
    .token_precision_out (tpo),
    .mult_start          (mult_start),
    .mult_done           (mult_done),
    .busy                (busy),
    .batch_done          (batch_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: expected buses and handshake outputs
  logic [DW-1:0] m_A [NA];
  logic [DW-1:0] m_V [NV];
  logic [3:0]    m_P [L];
  bit            m_ready, m_start, m_busy, m_bdone, m_valid;
  int            m_beats;
  int            m_cls;

  // Monitors
  int cyc = 0;
  bit last_ready, last_start, last_busy, last_bdone;
  int ready_cnt = 0, start_cnt = 0, bdone_cnt = 0;
  int start_cyc = 0, bd_cyc = 0, done_cyc = 0;
  bit bd_ready;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Stream contents by test kind and flat beat index
  function automatic logic [DW-1:0] val(input int kind, input int idx);
    int v, t, e;
    v = idx - NA;
    t = v / TOK;
    e = v % TOK;
    case (kind)
      0: return (idx < NA) ? DW'(idx) : DW'(256 + v);
      1: return (idx < NA) ? DW'(16'hA000 + idx * 3) : DW'(16'h5000 ^ v);
      2: return (idx < NA) ? DW'(idx * 7) : DW'(16'h20 + v);
      default: begin
        if (idx < NA) return DW'(65535 - idx);
        if (t == 0) return 16'h0003;
        if (t == 1) return (e == 3) ? 16'h0050 : 16'h0002;
        if (t == 2) return (e == 5) ? 16'h1200 : 16'h0001;
        return DW'(e);
      end
    endcase
  endfunction

  // Precision code driven with each beat; only token-first V beats should count
  function automatic logic [3:0] pr(input int kind, input int idx);
    int v, t;
    v = idx - NA;
    t = v / TOK;
    if (idx < NA) return 4'(idx & 15);
    if (v % TOK != 0) return 4'((v * 5 + 3) & 15);
    if (kind == 0) return 4'(t % 3);
    return 4'((t * kind + 1) & 15);
  endfunction

  function automatic int cls(input logic [DW-1:0] d);
    if (d >= 256) return 2;
    if (d >= 16) return 1;
    return 0;
  endfunction

  function automatic logic [DW-1:0] a_el(input int i);
    return A_out[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] v_el(input int i);
    return V_out[i*DW +: DW];
  endfunction

  // Model update on a clock edge from the inputs presented in that cycle
  task automatic model_step();
    bit acc, fin;
    int v;
    if (rst) begin
      for (int i = 0; i < NA; i++) m_A[i] = '0;
      for (int i = 0; i < NV; i++) m_V[i] = '0;
      for (int i = 0; i < L; i++)  m_P[i] = '0;
      m_ready = 0; m_start = 0; m_busy = 0; m_bdone = 0;
      m_beats = 0; m_cls = 0; m_valid = 1;
    end else begin
      acc = s_valid && m_ready;
      fin = 0;
      if (acc) begin
        if (m_beats < NA) begin
          m_A[m_beats] = s_data;
        end else begin
          v = m_beats - NA;
          m_V[v] = s_data;
`ifdef AUTO_PRECISION_EN
          if (v % TOK == 0) m_cls = cls(s_data);
          else if (cls(s_data) > m_cls) m_cls = cls(s_data);
          if (v % TOK == TOK - 1) m_P[v / TOK] = 4'(m_cls);
`else
          if (v % TOK == 0) m_P[v / TOK] = s_prec;
`endif
        end
        m_beats++;
        if (m_beats == NBEAT) begin
          fin = 1;
          m_beats = 0;
        end
      end
      m_start = fin;
      m_bdone = m_busy && mult_done;
      m_busy  = (m_busy && !mult_done) || fin;
      m_ready = !m_busy;
    end
  endtask

  // One clock cycle: compare at negedge, advance model at posedge
  task automatic tick();
    int bad, k;
    @(negedge clk);
    last_ready = s_ready;
    last_start = mult_start;
    last_busy  = busy;
    last_bdone = batch_done;
    if (m_valid) begin
      chk("s_ready", s_ready, m_ready);
      chk("mult_start", mult_start, m_start);
      chk("busy", busy, m_busy);
      chk("batch_done", batch_done, m_bdone);
      bad = -1;
      for (int i = 0; i < NA; i++) if (bad < 0 && a_el(i) !== m_A[i]) bad = i;
      k = (bad < 0) ? 0 : bad;
      chk($sformatf("A_out[%0d]", k), a_el(k), m_A[k]);
      bad = -1;
      for (int i = 0; i < NV; i++) if (bad < 0 && v_el(i) !== m_V[i]) bad = i;
      k = (bad < 0) ? 0 : bad;
      chk($sformatf("V_out[%0d]", k), v_el(k), m_V[k]);
      bad = -1;
      for (int i = 0; i < L; i++) if (bad < 0 && tpo[i] !== m_P[i]) bad = i;
      k = (bad < 0) ? 0 : bad;
      chk($sformatf("token_precision_out[%0d]", k), tpo[k], m_P[k]);
    end
    if (s_ready) ready_cnt++;
    if (mult_start) begin start_cnt++; start_cyc = cyc; end
    if (batch_done) begin bdone_cnt++; bd_cyc = cyc; bd_ready = s_ready; end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  // Present beats first..last-1, advancing only on an observed handshake
  task automatic stream(input int kind, input bit gaps, input int first, input int last);
    int idx = first;
    int budget = 0;
    while (idx < last && budget < 1000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = val(kind, idx);
      s_prec  = pr(kind, idx);
      tick();
      if (s_valid && last_ready) idx++;
      budget++;
    end
    if (idx < last) chk("stream_timeout", idx, last);
  endtask

  // Called in the start cycle; done is raised d cycles after start
  task automatic finish_batch(input int d);
    tick();
    chk("start_latency", last_start, 1);
    chk("busy_in_start", last_busy, 1);
    for (int i = 1; i < d; i++) begin
      tick();
      chk("wait_busy", last_busy, 1);
      chk("wait_ready", last_ready, 0);
    end
    mult_done = 1'b1;
    done_cyc  = cyc;
    tick();
    mult_done = 1'b0;
    s_valid   = 1'b0;
  endtask

  task automatic pin_kind0();
    chk("pin_A0", a_el(0), 16'h0000);
    chk("pin_A63", a_el(63), 16'h003F);
    chk("pin_V63", v_el(63), 16'h013F);
    chk("pin_V0", v_el(0), 16'h0100);
`ifdef AUTO_PRECISION_EN
    for (int i = 0; i < L; i++) chk($sformatf("pin_prec%0d", i), tpo[i], 2);
`else
    // l2 mod 3 for l2 = 0..7
    chk("pin_prec0", tpo[0], 0); chk("pin_prec1", tpo[1], 1);
    chk("pin_prec2", tpo[2], 2); chk("pin_prec3", tpo[3], 0);
    chk("pin_prec4", tpo[4], 1); chk("pin_prec5", tpo[5], 2);
    chk("pin_prec6", tpo[6], 0); chk("pin_prec7", tpo[7], 1);
`endif
  endtask

  initial begin
    int r0, s0, b0, st1, st2;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_prec = '0; mult_done = 1'b0;
    m_valid = 0; m_ready = 0; m_start = 0; m_busy = 0; m_bdone = 0;
    m_beats = 0; m_cls = 0;
    @(posedge clk); #1;
    repeat (3) tick();

    // Reset state
    chk("rst_s_ready", last_ready, 0);
    chk("rst_busy", last_busy, 0);
    chk("rst_start", last_start, 0);
    chk("rst_A_zero", |A_out, 0);
    chk("rst_V_zero", |V_out, 0);

    // Full batch, s_valid held high, then 20 low cycles of mult_done
    rst = 1'b0;
    r0 = ready_cnt; s0 = start_cnt; b0 = bdone_cnt;
    stream(0, 0, 0, NBEAT);
    pin_kind0();
    finish_batch(20);
    chk("ready_cycles", ready_cnt - r0, 128);
    tick();
    chk("batch_done_once", bdone_cnt - b0, 1);
    chk("batch_done_cycle", bd_cyc, done_cyc + 1);
    chk("ready_after_done", bd_ready, 1);
    chk("start_once_t1", start_cnt - s0, 1);

    // Same data with random gaps on s_valid
    s0 = start_cnt;
    stream(0, 1, 0, NBEAT);
    pin_kind0();
    finish_batch(3);
    tick();
    chk("start_once_gaps", start_cnt - s0, 1);

    // Spurious done during A load, then reset after 30 A beats
    b0 = bdone_cnt;
    stream(1, 0, 0, 10);
    s_valid = 1'b0; mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    stream(1, 0, 10, 30);
    s_valid = 1'b0; rst = 1'b1;
    tick(); tick();
    chk("no_spurious_done", bdone_cnt - b0, 0);
    chk("midrst_A_zero", |A_out, 0);
    chk("midrst_V_zero", |V_out, 0);
    chk("midrst_ready", last_ready, 0);
    chk("midrst_busy", last_busy, 0);
    chk("midrst_prec7", tpo[7], 0);
    rst = 1'b0;
    stream(2, 0, 0, NBEAT);
    chk("pin_k2_A10", a_el(10), 16'h0046);
    chk("pin_k2_A63", a_el(63), 16'h01B9);
    chk("pin_k2_V0", v_el(0), 16'h0020);
    finish_batch(4);
    tick();

    // Back-to-back batches with a 5-cycle done response
    stream(1, 0, 0, NBEAT);
    finish_batch(5);
    st1 = start_cyc;
    stream(3, 0, 0, NBEAT);
    chk("b2b_done_cycle", bd_cyc, done_cyc + 1);
    chk("b2b_ready_after_done", bd_ready, 1);
    chk("pin_k3_A0", a_el(0), 16'hFFFF);
    chk("pin_k3_A63", a_el(63), 16'hFFC0);
    chk("pin_k3_V11", v_el(11), 16'h0050);
`ifdef AUTO_PRECISION_EN
    chk("auto_prec0", tpo[0], 0);
    chk("auto_prec1", tpo[1], 1);
    chk("auto_prec2", tpo[2], 2);
`else
    chk("pin_k3_prec0", tpo[0], 1);
    chk("pin_k3_prec1", tpo[1], 4);
    chk("pin_k3_prec2", tpo[2], 7);
`endif
    finish_batch(5);
    st2 = start_cyc;
    // 128 beats + start cycle + 4 low wait cycles + done cycle
    chk("batch_period", st2 - st1, 134);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
